// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-source arbiter.
// Fibonacci LFSR taps, default seed and the reseed FSM states.
package lfsr_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h088C_8892;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h00BD_5C5F;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_WARMUP
  } arb_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// 32-bit Fibonacci LFSR register.
// Load takes priority over a step; otherwise the state holds.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= load_val_i;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one LFSR among requesters.
// Also sequences reseeding: load, then a discard warm-up.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int                NUM_REQ       = 4,
  parameter logic [LFSR_W-1:0] SEED          = LFSR_SEED,
  parameter int                WARMUP_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [LFSR_W-1:0]  rand_o,
  input  logic [LFSR_W-1:0]  seed_i,
  input  logic               seed_load_i,
  output logic               busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] N_LIM = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e        state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [7:0]        cnt_q;
  logic [LFSR_W-1:0] seed_q;
  logic [LFSR_W-1:0] lfsr_s;
  logic [LFSR_W-1:0] load_val;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       idx_sum;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     ptr_n;
  logic [NUM_REQ-1:0]   gnt_d;
  logic                 any_req;
  logic                 grant;
  logic                 step;

  // Rotate so that bit 0 is the requester at ptr; lowest set bit wins.
  assign req_dbl = {req_i, req_i};
  assign req_rot = NUM_REQ'(req_dbl >> ptr_q);
  assign any_req = |req_i;

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PTR_W'(i);
    end
  end

  assign idx_sum = {1'b0, ptr_q} + {1'b0, off};
  assign win = (idx_sum >= N_LIM) ? PTR_W'(idx_sum - N_LIM)
                                  : PTR_W'(idx_sum);
  assign ptr_n = (win == LAST) ? '0 : win + PTR_W'(1);
  assign gnt_d = NUM_REQ'(1) << win;

  assign grant = (state_q == ST_RUN) && !seed_load_i && any_req;
  assign step  = grant ||
                 ((state_q == ST_WARMUP) && !seed_load_i);

  assign load_val = (seed_q == '0) ? SEED : seed_q;

  lfsr_step #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .en_i       (step),
    .load_i     (state_q == ST_LOAD),
    .load_val_i (load_val),
    .state_o    (lfsr_s)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
      gnt_o   <= '0;
      rand_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      gnt_o <= '0;
      unique case (state_q)
        ST_RUN: begin
          if (seed_load_i) begin
            seed_q  <= seed_i;
            state_q <= ST_LOAD;
            busy_o  <= 1'b1;
          end else if (any_req) begin
            gnt_o  <= gnt_d;
            rand_o <= lfsr_s;
            ptr_q  <= ptr_n;
          end
        end
        ST_LOAD: begin
          if (seed_load_i) begin
            seed_q <= seed_i;
          end else begin
            cnt_q   <= 8'(WARMUP_CYCLES - 1);
            state_q <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (seed_load_i) begin
            seed_q  <= seed_i;
            state_q <= ST_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= ST_RUN;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
